uart_fifo: RTL and testbench
============================

Name: uart_fifo

Overview:
Synchronous first-word-fall-through byte FIFO that buffers traffic between the UART controllers and the calculator core.
- Tx direction: the core writes result bytes. uart_transmitter_controler pulls them through its din/empty/re interface.
- Rx direction: uart_receiver_controler pushes bytes through its dout/we/full interface. The core pops them.
- Absorbs bursts, e.g. the 14-byte command line "6 2 + 3 1 - *\r" arriving faster than the core consumes it.

Parameters:
WIDTH, 8, data width in bits
DEPTH_LOG2, 4, log2 of storage depth (16 entries)

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous active-low reset
din  in  WIDTH  write data
we  in  1  write request
full  out  1  no free entry
dout  out  WIDTH  head-of-queue data (FWFT)
re  in  1  read/pop request
empty  out  1  no valid entry
count  out  DEPTH_LOG2+1  number of stored entries, 0..2**DEPTH_LOG2
overflow  out  1  sticky: write attempted while full and not simultaneously popped
underflow  out  1  sticky: read attempted while empty
clr_err  in  1  synchronous clear of overflow/underflow

Behaviour:
- Reset (rst=0, async): wptr=0, rptr=0, count=0, empty=1, full=0, overflow=0, underflow=0, dout=0. Storage contents are not reset.
- Pointers are DEPTH_LOG2 bits and wrap modulo 2**DEPTH_LOG2. Count is held in a separate register; full = (count==2**DEPTH_LOG2), empty = (count==0). Both flags are registered-equivalent: a function of count only.
- Write accepted (wr_ok) = we && (!full || re). On wr_ok: mem[wptr]<=din, wptr<=wptr+1.
- Read accepted (rd_ok) = re && !empty. On rd_ok: rptr<=rptr+1.
- count next = count + wr_ok - rd_ok.
- Simultaneous we&&re when full: both accepted, count unchanged, full stays 1.
- Simultaneous we&&re when empty: write accepted, read ignored, underflow set, count becomes 1.
- FWFT output:
  - dout = mem[rptr] when !empty, else 0 (combinational from registered storage).
  - Latency: a byte written in cycle N is visible on dout with empty=0 in cycle N+1.
  - On a pop, the next entry appears the following cycle.
- Sticky flags:
  - overflow <= 1 when we && full && !re.
  - underflow <= 1 when re && empty.
  - clr_err=1 clears both; a set condition in the same cycle wins over clr.
  - The dropped write, or the ignored read, has no other effect.
- Reset mid-operation: all queued data is discarded, outputs return to reset values immediately. The first write after reset release lands in entry 0.
- No combinational path from din to dout. A path from re to full through wr_ok is permitted. No path from we to empty.

Decomposition:
- Package uart_pkg holds: UART_DATA_W=8, FIFO_DEPTH_LOG2=4, and typedef logic [UART_DATA_W-1:0] uart_byte_t. The core, both UART controllers and this FIFO share these.
- One sub-module, uart_fifo_ram: simple dual-port register array with one write port and one asynchronous read port, no reset.
- Pointer, count and flag logic stay in uart_fifo.

Test Plan:
1. Reset then idle → empty=1, full=0, count=0, dout=0, overflow=0, underflow=0.
2. Write 0x36 then 0x20 on consecutive cycles, then pop twice → cycle after first write: dout=0x36, empty=0. After first pop: dout=0x20. After second pop: empty=1, dout=0, count=0.
3. Write 17 bytes 0x00..0x10 with no reads → full=1 after the 16th, count=16, overflow=1. Draining yields 0x00..0x0F in order, with 0x10 absent.
4. Full FIFO plus simultaneous we=1 (din=0xAA) and re=1 → count stays 16, overflow stays 0. After draining, 0xAA appears last.
5. Empty FIFO plus re=1 → underflow=1. Then clr_err=1 → underflow=0. Same-cycle re&&empty together with clr_err → underflow=1.
6. Wrap-around: stream 40 bytes of "6 2 + 3 1 - *\r" repeated, with 1 read per 2 writes, then drain → output order identical to input, no overflow. Assert rst=0 mid-stream → empty=1 and count=0 immediately, first post-reset byte read back correctly.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART-side types and sizes used by the core, the UART controllers and the byte FIFO.
package uart_pkg;
  localparam int UART_DATA_W     = 8;
  localparam int FIFO_DEPTH_LOG2 = 4;
  localparam int FIFO_DEPTH      = 1 << FIFO_DEPTH_LOG2;

  typedef logic [UART_DATA_W-1:0] uart_byte_t;
endpackage

// File: rtl/uart_fifo_if.sv
// Byte FIFO bus: master is the producer/consumer side, slave is the FIFO itself.
interface uart_fifo_if #(
  parameter int WIDTH      = 8,
  parameter int DEPTH_LOG2 = 4
);
  logic [WIDTH-1:0]    din;
  logic                we;
  logic                full;
  logic [WIDTH-1:0]    dout;
  logic                re;
  logic                empty;
  logic [DEPTH_LOG2:0] count;
  logic                overflow;
  logic                underflow;
  logic                clr_err;

  modport master (
    output din, we, re, clr_err,
    input  full, dout, empty, count, overflow, underflow
  );

  modport slave (
    input  din, we, re, clr_err,
    output full, dout, empty, count, overflow, underflow
  );
endinterface

// File: rtl/uart_fifo_ram.sv
// Register-array storage for the byte FIFO: one synchronous write port, one asynchronous read port.
module uart_fifo_ram #(
  parameter int WIDTH = 8,
  parameter int AW    = 4
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);
  localparam int DEPTH = 1 << AW;

  logic [WIDTH-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem_q[waddr] <= wdata;
  end

  assign rdata = mem_q[raddr];
endmodule

// File: rtl/uart_fifo.sv
// First-word-fall-through byte FIFO between the UART controllers and the calculator core.
// Occupancy lives in its own counter so full/empty depend on count only, never on the pointers.
module uart_fifo
  import uart_pkg::*;
#(
  parameter int WIDTH      = UART_DATA_W,
  parameter int DEPTH_LOG2 = FIFO_DEPTH_LOG2
) (
  input  logic       clk,
  input  logic       rst,
  uart_fifo_if.slave fifo
);
  localparam logic [DEPTH_LOG2:0] FULL_CNT = {1'b1, {DEPTH_LOG2{1'b0}}};

  logic [DEPTH_LOG2-1:0] wptr_q, wptr_d;
  logic [DEPTH_LOG2-1:0] rptr_q, rptr_d;
  logic [DEPTH_LOG2:0]   count_q, count_d;
  logic                  ovf_q, ovf_d;
  logic                  udf_q, udf_d;
  logic                  full, empty, wr_ok, rd_ok;
  logic [WIDTH-1:0]      rd_data;

  assign full  = (count_q == FULL_CNT);
  assign empty = (count_q == '0);
  // A pop in the same cycle frees the slot, so a write into a full FIFO still lands.
  assign wr_ok = fifo.we && (!full || fifo.re);
  assign rd_ok = fifo.re && !empty;

  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    if (wr_ok) wptr_d = wptr_q + DEPTH_LOG2'(1);
    if (rd_ok) rptr_d = rptr_q + DEPTH_LOG2'(1);
    case ({wr_ok, rd_ok})
      2'b10:   count_d = count_q + (DEPTH_LOG2+1)'(1);
      2'b01:   count_d = count_q - (DEPTH_LOG2+1)'(1);
      default: count_d = count_q;
    endcase
    // Setting beats clearing when both happen in one cycle.
    ovf_d = (fifo.we && full && !fifo.re) || (ovf_q && !fifo.clr_err);
    udf_d = (fifo.re && empty) || (udf_q && !fifo.clr_err);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
      ovf_q   <= 1'b0;
      udf_q   <= 1'b0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
      ovf_q   <= ovf_d;
      udf_q   <= udf_d;
    end
  end

  uart_fifo_ram #(.WIDTH(WIDTH), .AW(DEPTH_LOG2)) u_ram (
    .clk   (clk),
    .we    (wr_ok),
    .waddr (wptr_q),
    .wdata (fifo.din),
    .raddr (rptr_q),
    .rdata (rd_data)
  );

  assign fifo.dout      = empty ? '0 : rd_data;
  assign fifo.full      = full;
  assign fifo.empty     = empty;
  assign fifo.count     = count_q;
  assign fifo.overflow  = ovf_q;
  assign fifo.underflow = udf_q;
endmodule

// File: tb/tb_uart_fifo.sv
// Self-checking bench for uart_fifo against a queue-based reference model.
module tb_uart_fifo;
  import uart_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  uart_fifo_if #(.WIDTH(UART_DATA_W), .DEPTH_LOG2(FIFO_DEPTH_LOG2)) bus ();

  uart_fifo #(.WIDTH(UART_DATA_W), .DEPTH_LOG2(FIFO_DEPTH_LOG2)) dut (
    .clk  (clk),
    .rst  (rst),
    .fifo (bus)
  );

  int total = 0;
  int bad   = 0;

  // Reference model: ordered queue of stored bytes plus the two sticky flags.
  uart_byte_t mq[$];
  bit         m_ovf, m_udf;

  uart_byte_t cmd [14] = '{8'h36, 8'h20, 8'h32, 8'h20, 8'h2B, 8'h20, 8'h33,
                           8'h20, 8'h31, 8'h20, 8'h2D, 8'h20, 8'h2A, 8'h0D};

  function automatic uart_byte_t m_dout();
    return (mq.size() > 0) ? mq[0] : 8'h00;
  endfunction

  task automatic model_reset();
    mq.delete();
    m_ovf = 1'b0;
    m_udf = 1'b0;
  endtask

  // Drive one cycle of stimulus, advance the model at the clock edge, return #1 after it.
  task automatic step(input bit we, input uart_byte_t din, input bit re, input bit clr);
    bit full_now, empty_now, wr_ok, rd_ok;
    uart_byte_t tmp;
    bus.we = we; bus.din = din; bus.re = re; bus.clr_err = clr;
    full_now  = (mq.size() == FIFO_DEPTH);
    empty_now = (mq.size() == 0);
    wr_ok = we && (!full_now || re);
    rd_ok = re && !empty_now;
    @(posedge clk);
    if (rd_ok) tmp = mq.pop_front();
    if (wr_ok) mq.push_back(din);
    m_ovf = (we && full_now && !re) || (m_ovf && !clr);
    m_udf = (re && empty_now) || (m_udf && !clr);
    #1;
    bus.we = 1'b0; bus.re = 1'b0; bus.clr_err = 1'b0;
  endtask

  task automatic test_reset();
    bus.we = 1'b0; bus.re = 1'b0; bus.clr_err = 1'b0; bus.din = '0;
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    total++; if (bus.empty !== 1'b1) begin bad++; $display("FAIL reset_empty got=%b want=1", bus.empty); end
    total++; if (bus.full !== 1'b0) begin bad++; $display("FAIL reset_full got=%b want=0", bus.full); end
    total++; if (bus.count !== '0) begin bad++; $display("FAIL reset_count got=%0d want=0", bus.count); end
    total++; if (bus.dout !== 8'h00) begin bad++; $display("FAIL reset_dout got=%h want=00", bus.dout); end
    total++; if (bus.overflow !== 1'b0) begin bad++; $display("FAIL reset_ovf got=%b want=0", bus.overflow); end
    total++; if (bus.underflow !== 1'b0) begin bad++; $display("FAIL reset_udf got=%b want=0", bus.underflow); end
  endtask

  task automatic test_fwft();
    step(1'b1, 8'h36, 1'b0, 1'b0);
    total++; if (bus.dout !== 8'h36) begin bad++; $display("FAIL fwft_first_dout got=%h want=36", bus.dout); end
    total++; if (bus.empty !== 1'b0) begin bad++; $display("FAIL fwft_first_empty got=%b want=0", bus.empty); end
    step(1'b1, 8'h20, 1'b0, 1'b0);
    step(1'b0, 8'h00, 1'b1, 1'b0);
    total++; if (bus.dout !== 8'h20) begin bad++; $display("FAIL fwft_pop1_dout got=%h want=20", bus.dout); end
    step(1'b0, 8'h00, 1'b1, 1'b0);
    total++; if (bus.empty !== 1'b1) begin bad++; $display("FAIL fwft_pop2_empty got=%b want=1", bus.empty); end
    total++; if (bus.dout !== 8'h00) begin bad++; $display("FAIL fwft_pop2_dout got=%h want=00", bus.dout); end
    total++; if (bus.count !== '0) begin bad++; $display("FAIL fwft_pop2_count got=%0d want=0", bus.count); end
  endtask

  task automatic test_overflow();
    for (int i = 0; i < 17; i++) begin
      step(1'b1, 8'(i), 1'b0, 1'b0);
      if (i == 15) begin
        total++; if (bus.full !== 1'b1) begin bad++; $display("FAIL ovf_full16 got=%b want=1", bus.full); end
        total++; if (bus.overflow !== 1'b0) begin bad++; $display("FAIL ovf_early got=%b want=0", bus.overflow); end
      end
    end
    total++; if (int'(bus.count) !== 16) begin bad++; $display("FAIL ovf_count got=%0d want=16", bus.count); end
    total++; if (bus.overflow !== 1'b1) begin bad++; $display("FAIL ovf_flag got=%b want=1", bus.overflow); end
    for (int i = 0; i < 16; i++) begin
      total++; if (bus.dout !== 8'(i)) begin bad++; $display("FAIL ovf_drain[%0d] got=%h want=%h", i, bus.dout, 8'(i)); end
      step(1'b0, 8'h00, 1'b1, 1'b0);
    end
    total++; if (bus.empty !== 1'b1) begin bad++; $display("FAIL ovf_drained_empty got=%b want=1", bus.empty); end
    step(1'b0, 8'h00, 1'b0, 1'b1);
    total++; if (bus.overflow !== 1'b0) begin bad++; $display("FAIL ovf_clr got=%b want=0", bus.overflow); end
  endtask

  task automatic test_full_rw();
    for (int i = 0; i < 16; i++) step(1'b1, 8'($urandom_range(0, 255)), 1'b0, 1'b0);
    step(1'b1, 8'hAA, 1'b1, 1'b0);
    total++; if (int'(bus.count) !== 16) begin bad++; $display("FAIL fullrw_count got=%0d want=16", bus.count); end
    total++; if (bus.full !== 1'b1) begin bad++; $display("FAIL fullrw_full got=%b want=1", bus.full); end
    total++; if (bus.overflow !== 1'b0) begin bad++; $display("FAIL fullrw_ovf got=%b want=0", bus.overflow); end
    for (int i = 0; i < 16; i++) begin
      total++; if (bus.dout !== m_dout()) begin bad++; $display("FAIL fullrw_drain[%0d] got=%h want=%h", i, bus.dout, m_dout()); end
      if (i == 15) begin
        total++; if (bus.dout !== 8'hAA) begin bad++; $display("FAIL fullrw_last got=%h want=aa", bus.dout); end
      end
      step(1'b0, 8'h00, 1'b1, 1'b0);
    end
  endtask

  task automatic test_underflow();
    step(1'b0, 8'h00, 1'b1, 1'b0);
    total++; if (bus.underflow !== 1'b1) begin bad++; $display("FAIL udf_set got=%b want=1", bus.underflow); end
    total++; if (bus.count !== '0) begin bad++; $display("FAIL udf_count got=%0d want=0", bus.count); end
    step(1'b0, 8'h00, 1'b0, 1'b1);
    total++; if (bus.underflow !== 1'b0) begin bad++; $display("FAIL udf_clr got=%b want=0", bus.underflow); end
    step(1'b0, 8'h00, 1'b1, 1'b1);
    total++; if (bus.underflow !== 1'b1) begin bad++; $display("FAIL udf_set_wins got=%b want=1", bus.underflow); end
    step(1'b0, 8'h00, 1'b0, 1'b1);
    // Write and read into an empty FIFO: write lands, read is ignored.
    step(1'b1, 8'h55, 1'b1, 1'b0);
    total++; if (int'(bus.count) !== 1) begin bad++; $display("FAIL udf_wr_rd_count got=%0d want=1", bus.count); end
    total++; if (bus.dout !== 8'h55) begin bad++; $display("FAIL udf_wr_rd_dout got=%h want=55", bus.dout); end
    total++; if (bus.underflow !== 1'b1) begin bad++; $display("FAIL udf_wr_rd_flag got=%b want=1", bus.underflow); end
    step(1'b0, 8'h00, 1'b1, 1'b1);
    total++; if (bus.empty !== 1'b1 || bus.underflow !== 1'b0) begin bad++; $display("FAIL udf_final empty=%b udf=%b want=1/0", bus.empty, bus.underflow); end
  endtask

  task automatic test_wrap();
    uart_byte_t got[$];
    bit re;
    for (int k = 0; k < 40; k++) begin
      re = ((k % 2) == 1) || (mq.size() >= 14);
      if (re && mq.size() > 0) got.push_back(bus.dout);
      step(1'b1, cmd[k % 14], re, 1'b0);
      total++; if (int'(bus.count) !== mq.size() || bus.dout !== m_dout()) begin
        bad++; $display("FAIL wrap_stream[%0d] count=%0d dout=%h want=%0d/%h", k, bus.count, bus.dout, mq.size(), m_dout());
      end
    end
    for (int g = 0; g < 40 && mq.size() > 0; g++) begin
      got.push_back(bus.dout);
      step(1'b0, 8'h00, 1'b1, 1'b0);
    end
    total++; if (got.size() !== 40) begin bad++; $display("FAIL wrap_len got=%0d want=40", got.size()); end
    for (int k = 0; k < 40 && k < got.size(); k++) begin
      total++; if (got[k] !== cmd[k % 14]) begin bad++; $display("FAIL wrap_order[%0d] got=%h want=%h", k, got[k], cmd[k % 14]); end
    end
    total++; if (bus.overflow !== 1'b0) begin bad++; $display("FAIL wrap_ovf got=%b want=0", bus.overflow); end
    // Reset in the middle of a stream.
    for (int k = 0; k < 5; k++) step(1'b1, cmd[k], 1'b0, 1'b0);
    #1 rst = 1'b0;
    #1;
    model_reset();
    total++; if (bus.empty !== 1'b1) begin bad++; $display("FAIL midrst_empty got=%b want=1", bus.empty); end
    total++; if (bus.count !== '0) begin bad++; $display("FAIL midrst_count got=%0d want=0", bus.count); end
    total++; if (bus.dout !== 8'h00) begin bad++; $display("FAIL midrst_dout got=%h want=00", bus.dout); end
    @(negedge clk);
    rst = 1'b1;
    step(1'b1, 8'h2A, 1'b0, 1'b0);
    total++; if (bus.dout !== 8'h2A || int'(bus.count) !== 1) begin bad++; $display("FAIL midrst_first dout=%h count=%0d want=2a/1", bus.dout, bus.count); end
    step(1'b0, 8'h00, 1'b1, 1'b0);
  endtask

  task automatic test_random();
    bit we, re, clr;
    for (int n = 0; n < 400; n++) begin
      we  = ($urandom_range(0, 9) < 6);
      re  = ($urandom_range(0, 9) < 5);
      clr = ($urandom_range(0, 7) == 0);
      step(we, 8'($urandom_range(0, 255)), re, clr);
      total++;
      if (bus.dout !== m_dout() || int'(bus.count) !== mq.size() ||
          bus.full !== (mq.size() == FIFO_DEPTH) || bus.empty !== (mq.size() == 0) ||
          bus.overflow !== m_ovf || bus.underflow !== m_udf) begin
        bad++;
        $display("FAIL rand[%0d] dout=%h cnt=%0d f=%b e=%b o=%b u=%b want=%h %0d %b %b %b %b", n,
                 bus.dout, bus.count, bus.full, bus.empty, bus.overflow, bus.underflow,
                 m_dout(), mq.size(), mq.size() == FIFO_DEPTH, mq.size() == 0, m_ovf, m_udf);
      end
    end
  endtask

  initial begin
    test_reset();
    test_fwft();
    test_overflow();
    test_full_rw();
    test_underflow();
    test_wrap();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
